// File: rtl/rc4_decrypt_stage_if.sv
// ---------------------------------------------------------------------------
// rc4_decrypt_stage_if
//   Bundles every non-clock/reset signal of the RC4 PRGA stage: control
//   strobes from loop 2 and the checker, the S-RAM port, the encrypted-ROM
//   read port, the decrypted-RAM write port and the character handshake.
//
//   Parameter
//     KW            width of the message index (k, char_count, ROM/RAM addr)
//
//   Signals (direction as seen by the PRGA stage, i.e. the master modport)
//     start         in   loop-2 done pulse, starts PRGA from IDLE
//     start_over    in   checker abort, synchronous return to IDLE
//     s_addr        out  S-RAM address
//     s_wrdata      out  S-RAM write data
//     s_wren        out  S-RAM write enable
//     s_rddata      in   S-RAM read data, one cycle after the address
//     enc_addr      out  encrypted-ROM address (= k)
//     enc_rddata    in   encrypted-ROM data, one cycle after the address
//     dec_addr      out  decrypted-RAM address (= k)
//     dec_wrdata    out  decrypted-RAM write data
//     dec_wren      out  decrypted-RAM write enable
//     new_char      out  char_out valid, held until acknowledged
//     char_out      out  decrypted byte
//     char_count    out  current k, MSG_LEN once the message is complete
//     compared_char in   checker acknowledge (level)
//     done          out  whole message decrypted and acknowledged
// ---------------------------------------------------------------------------
interface rc4_decrypt_stage_if #(
    parameter int KW = 6
);
    logic          start;
    logic          start_over;

    logic [7:0]    s_addr;
    logic [7:0]    s_wrdata;
    logic          s_wren;
    logic [7:0]    s_rddata;

    logic [KW-1:0] enc_addr;
    logic [7:0]    enc_rddata;

    logic [KW-1:0] dec_addr;
    logic [7:0]    dec_wrdata;
    logic          dec_wren;

    logic          new_char;
    logic [7:0]    char_out;
    logic [KW-1:0] char_count;
    logic          compared_char;
    logic          done;

    // The PRGA stage drives the memory buses and the character handshake.
    modport master (
        input  start, start_over, s_rddata, enc_rddata, compared_char,
        output s_addr, s_wrdata, s_wren, enc_addr, dec_addr, dec_wrdata,
               dec_wren, new_char, char_out, char_count, done
    );

    // Memories, loop 2 and the checker sit on the other side.
    modport slave (
        output start, start_over, s_rddata, enc_rddata, compared_char,
        input  s_addr, s_wrdata, s_wren, enc_addr, dec_addr, dec_wrdata,
               dec_wren, new_char, char_out, char_count, done
    );
endinterface

// File: rtl/rc4_decrypt_stage.sv
// ---------------------------------------------------------------------------
// rc4_decrypt_stage
//   RC4 PRGA stage (loop 3) of the key-search datapath. After loop 2 has
//   scrambled S, this block produces one keystream byte per message position:
//     i = i+1; si = S[i]; j = j+si; sj = S[j]; S[i] = sj; S[j] = si;
//     f = S[si+sj]; dec[k] = f ^ enc[k]
//   (all index arithmetic 8-bit, wrapping mod 256), writes the plaintext to
//   the decrypted RAM and presents it to the character checker, waiting for
//   compared_char before moving on. start_over from the checker aborts the
//   run at any point so the next key can be tried.
//
//   Parameters
//     MSG_LEN   message length in bytes (k runs 0..MSG_LEN-1)
//     KW        width of k / char_count, must be able to hold MSG_LEN
//
//   Ports
//     clok      in   system clock, all logic on the rising edge
//     resetm    in   synchronous active-low reset
//     bus       master side of rc4_decrypt_stage_if (memories + handshake)
//
//   Every output is a register. Memory addresses are set on the edge that
//   enters the state which owns them, so the RAM/ROM sees them for that whole
//   state and the read data is sampled one state later (the WAIT_* states).
//   Latency: 10 clocks from start to the first new_char, 11 clocks from the
//   acknowledge to the next new_char.
// ---------------------------------------------------------------------------
module rc4_decrypt_stage #(
    parameter int MSG_LEN = 32,
    parameter int KW      = 6
) (
    input logic                 clok,
    input logic                 resetm,
    rc4_decrypt_stage_if.master bus
);

    typedef enum logic [3:0] {
        IDLE,
        RD_SI,
        WAIT_SI,
        RD_SJ,
        WAIT_SJ,
        WR_SI,
        WR_SJ,
        RD_F,
        WAIT_F,
        WR_DEC,
        PRESENT,
        ACKED,
        DONE
    } state_t;

    localparam logic [KW-1:0] LP_MSG_LEN = KW'(MSG_LEN);

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t        r_state;
    logic [7:0]    r_i;
    logic [7:0]    r_j;
    logic [7:0]    r_si;
    logic [7:0]    r_sj;
    logic [KW-1:0] r_k;

    // Registered outputs
    logic [7:0]    r_s_addr;
    logic [7:0]    r_s_wrdata;
    logic          r_s_wren;
    logic [KW-1:0] r_enc_addr;
    logic [KW-1:0] r_dec_addr;
    logic [7:0]    r_dec_wrdata;
    logic          r_dec_wren;
    logic          r_new_char;
    logic [7:0]    r_char_out;
    logic          r_done;

    // -----------------------------------------------------------------------
    // Next-value arithmetic (8-bit wrap for i/j/si+sj comes from the widths)
    // -----------------------------------------------------------------------
    logic [7:0]    w_i_next;
    logic [7:0]    w_j_next;
    logic [7:0]    w_f_addr;
    logic [7:0]    w_plain;
    logic [KW-1:0] w_k_next;
    logic          w_last_byte;

    assign w_i_next    = r_i + 8'd1;
    assign w_j_next    = r_j + bus.s_rddata;
    assign w_f_addr    = r_si + r_sj;
    assign w_plain     = bus.s_rddata ^ bus.enc_rddata;
    assign w_k_next    = r_k + KW'(1);
    assign w_last_byte = (w_k_next == LP_MSG_LEN);

    // -----------------------------------------------------------------------
    // Single FSM process with registered outputs
    // -----------------------------------------------------------------------
    // NOTE: every register here is assigned with <= so all of them update
    // together on the edge; a blocking assignment would let later statements
    // see the new value of an earlier one and silently change the algorithm.
    always_ff @(posedge clok) begin
        // Reset and the checker abort land in the same clean IDLE state;
        // any write presented in the aborted cycle is simply dropped, since
        // loop 1 re-initialises S before the next key anyway.
        if (!resetm || bus.start_over) begin
            r_state      <= IDLE;
            r_i          <= 8'd0;
            r_j          <= 8'd0;
            r_si         <= 8'd0;
            r_sj         <= 8'd0;
            r_k          <= '0;
            r_s_addr     <= 8'd0;
            r_s_wrdata   <= 8'd0;
            r_s_wren     <= 1'b0;
            r_enc_addr   <= '0;
            r_dec_addr   <= '0;
            r_dec_wrdata <= 8'd0;
            r_dec_wren   <= 1'b0;
            r_new_char   <= 1'b0;
            r_char_out   <= 8'd0;
            r_done       <= 1'b0;
        end else begin
            // NOTE: write enables default low every cycle, so each one is
            // high only in the single state that sets it and never lingers.
            r_s_wren   <= 1'b0;
            r_dec_wren <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_i      <= w_i_next;
                        r_s_addr <= w_i_next;
                        r_state  <= RD_SI;
                    end
                end

                RD_SI: r_state <= WAIT_SI;

                WAIT_SI: begin
                    r_si     <= bus.s_rddata;
                    r_j      <= w_j_next;
                    r_s_addr <= w_j_next;
                    r_state  <= RD_SJ;
                end

                RD_SJ: r_state <= WAIT_SJ;

                WAIT_SJ: begin
                    r_sj       <= bus.s_rddata;
                    r_s_addr   <= r_i;
                    r_s_wrdata <= bus.s_rddata;
                    r_s_wren   <= 1'b1;
                    r_state    <= WR_SI;
                end

                // The S[j] write comes second, so with i == j the cell ends
                // up holding si, i.e. the swap leaves it unchanged.
                WR_SI: begin
                    r_s_addr   <= r_j;
                    r_s_wrdata <= r_si;
                    r_s_wren   <= 1'b1;
                    r_state    <= WR_SJ;
                end

                WR_SJ: begin
                    r_s_addr   <= w_f_addr;
                    r_enc_addr <= r_k;
                    r_state    <= RD_F;
                end

                RD_F: r_state <= WAIT_F;

                WAIT_F: begin
                    r_dec_addr   <= r_k;
                    r_dec_wrdata <= w_plain;
                    r_dec_wren   <= 1'b1;
                    r_char_out   <= w_plain;
                    r_state      <= WR_DEC;
                end

                WR_DEC: begin
                    r_new_char <= 1'b1;
                    r_state    <= PRESENT;
                end

                PRESENT: begin
                    if (bus.compared_char) begin
                        r_new_char <= 1'b0;
                        r_state    <= ACKED;
                    end
                end

                ACKED: begin
                    r_k <= w_k_next;
                    if (w_last_byte) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_i      <= w_i_next;
                        r_s_addr <= w_i_next;
                        r_state  <= RD_SI;
                    end
                end

                // Hold with done=1 and char_count=MSG_LEN until start_over.
                DONE: r_state <= DONE;

                default: r_state <= IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output mapping
    // -----------------------------------------------------------------------
    assign bus.s_addr     = r_s_addr;
    assign bus.s_wrdata   = r_s_wrdata;
    assign bus.s_wren     = r_s_wren;
    assign bus.enc_addr   = r_enc_addr;
    assign bus.dec_addr   = r_dec_addr;
    assign bus.dec_wrdata = r_dec_wrdata;
    assign bus.dec_wren   = r_dec_wren;
    assign bus.new_char   = r_new_char;
    assign bus.char_out   = r_char_out;
    assign bus.char_count = r_k;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_rc4_decrypt_stage.sv
// ---------------------------------------------------------------------------
// tb_rc4_decrypt_stage
//   Two instances share one set of memory models: a 32-byte build (A) and a
//   300-byte build (B) whose run takes i past 255. Only the selected instance
//   receives start; start_over, resetm and compared_char go to both.
//   Expected bytes come from a plain-integer RC4 model (KSA + PRGA on arrays).
// ---------------------------------------------------------------------------
module tb_rc4_decrypt_stage;

    localparam int LEN_A = 32;
    localparam int KW_A  = 6;
    localparam int LEN_B = 300;
    localparam int KW_B  = 9;

    logic clok = 1'b0;
    logic resetm = 1'b0;
    logic start = 1'b0;
    logic start_over = 1'b0;
    logic compared_char = 1'b0;
    logic sel = 1'b0;

    always #5 clok = ~clok;

    rc4_decrypt_stage_if #(.KW(KW_A)) bus_a ();
    rc4_decrypt_stage_if #(.KW(KW_B)) bus_b ();

    rc4_decrypt_stage #(.MSG_LEN(LEN_A), .KW(KW_A)) dut_a (
        .clok   (clok),
        .resetm (resetm),
        .bus    (bus_a)
    );

    rc4_decrypt_stage #(.MSG_LEN(LEN_B), .KW(KW_B)) dut_b (
        .clok   (clok),
        .resetm (resetm),
        .bus    (bus_b)
    );

    // ---------------- memories shared by both instances -------------------
    logic [7:0] s_mem   [256];
    logic [7:0] enc_mem [LEN_B];
    logic [7:0] dec_mem [LEN_B];
    logic [7:0] s_rd;
    logic [7:0] enc_rd;

    logic [7:0] m_s_addr, m_s_wrdata, m_dec_wrdata, m_char_out;
    logic       m_s_wren, m_dec_wren, m_new_char, m_done;
    logic [8:0] m_enc_addr, m_dec_addr, m_char_count;

    always_comb begin
        if (sel) begin
            m_s_addr     = bus_b.s_addr;
            m_s_wrdata   = bus_b.s_wrdata;
            m_s_wren     = bus_b.s_wren;
            m_enc_addr   = bus_b.enc_addr;
            m_dec_addr   = bus_b.dec_addr;
            m_dec_wrdata = bus_b.dec_wrdata;
            m_dec_wren   = bus_b.dec_wren;
            m_new_char   = bus_b.new_char;
            m_char_out   = bus_b.char_out;
            m_char_count = bus_b.char_count;
            m_done       = bus_b.done;
        end else begin
            m_s_addr     = bus_a.s_addr;
            m_s_wrdata   = bus_a.s_wrdata;
            m_s_wren     = bus_a.s_wren;
            m_enc_addr   = 9'(bus_a.enc_addr);
            m_dec_addr   = 9'(bus_a.dec_addr);
            m_dec_wrdata = bus_a.dec_wrdata;
            m_dec_wren   = bus_a.dec_wren;
            m_new_char   = bus_a.new_char;
            m_char_out   = bus_a.char_out;
            m_char_count = 9'(bus_a.char_count);
            m_done       = bus_a.done;
        end
    end

    assign bus_a.start         = start & ~sel;
    assign bus_b.start         = start & sel;
    assign bus_a.start_over    = start_over;
    assign bus_b.start_over    = start_over;
    assign bus_a.compared_char = compared_char;
    assign bus_b.compared_char = compared_char;
    assign bus_a.s_rddata      = s_rd;
    assign bus_b.s_rddata      = s_rd;
    assign bus_a.enc_rddata    = enc_rd;
    assign bus_b.enc_rddata    = enc_rd;

    // Synchronous memories: read data one cycle after the address.
    always @(posedge clok) begin
        s_rd   <= s_mem[m_s_addr];
        enc_rd <= enc_mem[m_enc_addr];
        if (m_s_wren)
            s_mem[m_s_addr] = m_s_wrdata;
        if (m_dec_wren)
            dec_mem[m_dec_addr] = m_dec_wrdata;
    end

    // Independent count of new_char rising edges.
    logic nc_prev = 1'b0;
    int   nc_rises = 0;
    always @(posedge clok) begin
        if (m_new_char && !nc_prev)
            nc_rises = nc_rises + 1;
        nc_prev <= m_new_char;
    end

    // ---------------- checking ---------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: new_char not seen within the cycle budget", name);
    endtask

    // ---------------- reference model --------------------------------------
    int         ref_s [256];
    int         ks    [LEN_B];
    logic [7:0] exp_pt[LEN_B];

    task automatic model_ksa(input int k0, input int k1, input int k2);
        int key[3];
        int j;
        int t;
        key[0] = k0; key[1] = k1; key[2] = k2;
        for (int x = 0; x < 256; x++) ref_s[x] = x;
        j = 0;
        for (int x = 0; x < 256; x++) begin
            j = (j + ref_s[x] + key[x % 3]) % 256;
            t = ref_s[x]; ref_s[x] = ref_s[j]; ref_s[j] = t;
        end
    endtask

    task automatic model_keystream(input int n);
        int w[256];
        int i;
        int j;
        int t;
        for (int x = 0; x < 256; x++) w[x] = ref_s[x];
        i = 0;
        j = 0;
        for (int k = 0; k < n; k++) begin
            i = (i + 1) % 256;
            j = (j + w[i]) % 256;
            t = w[i]; w[i] = w[j]; w[j] = t;
            ks[k] = w[(w[i] + w[j]) % 256];
        end
    endtask

    task automatic random_perm();
        int y;
        int t;
        for (int x = 0; x < 256; x++) ref_s[x] = x;
        for (int x = 255; x > 0; x--) begin
            y = $urandom_range(0, x);
            t = ref_s[x]; ref_s[x] = ref_s[y]; ref_s[y] = t;
        end
    endtask

    task automatic load_s();
        for (int x = 0; x < 256; x++) s_mem[x] = 8'(ref_s[x]);
    endtask

    // ---------------- stimulus helpers -------------------------------------
    task automatic abort();
        start_over = 1'b1;
        @(negedge clok);
        start_over = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clok);
        start = 1'b0;
    endtask

    // Counts negedges until new_char, bounded.
    task automatic wait_nc(output int cyc, output bit ok);
        cyc = 0;
        while (!m_new_char && cyc < 40) begin
            @(negedge clok);
            cyc++;
        end
        ok = m_new_char;
    endtask

    // Drives a started message to completion and checks every byte.
    task automatic run_message(input int n, input string tag);
        int cyc;
        bit ok;
        nc_rises = 0;
        for (int k = 0; k < n; k++) begin
            wait_nc(cyc, ok);
            if (!ok) begin
                fail_timeout($sformatf("%s byte %0d", tag, k));
                return;
            end
            check($sformatf("%s char_out[%0d]", tag, k), m_char_out, exp_pt[k]);
            check($sformatf("%s char_count[%0d]", tag, k), m_char_count, k);
            repeat ($urandom_range(0, 3)) @(negedge clok);
            compared_char = 1'b1;
            @(negedge clok);
            compared_char = 1'b0;
            check($sformatf("%s new_char low after ack %0d", tag, k), m_new_char, 0);
        end
        @(negedge clok);
        check({tag, " done"}, m_done, 1);
        check({tag, " final char_count"}, m_char_count, n);
        check({tag, " new_char pulses"}, nc_rises, n);
        for (int k = 0; k < n; k++)
            check($sformatf("%s dec[%0d]", tag, k), dec_mem[k], exp_pt[k]);
    endtask

    // ---------------- first-byte vectors -----------------------------------
    // S[x] = x + rot; f worked out by hand from the per-byte rules.
    typedef struct {
        logic [7:0] rot;
        logic [7:0] enc;
        logic [7:0] exp_char;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    cyc;
        int    n;
        int    wr_seen;
        bit    ok;
        string pt;

        vecs[0] = '{8'h00, 8'h00, 8'h02};  // identity: i=j=1, f=S[2]
        vecs[1] = '{8'h01, 8'hFF, 8'hF9};  // f=6
        vecs[2] = '{8'h02, 8'h0A, 8'h00};  // f=10
        vecs[3] = '{8'h10, 8'h5A, 8'h18};  // f=0x42
        vecs[4] = '{8'h55, 8'h0F, 8'hA4};  // si+sj wraps to 1 -> swapped S[1]=0xAB
        vecs[5] = '{8'hFF, 8'h01, 8'hFF};  // si=0, j=0, f=S[0xFF]=0xFE

        for (int x = 0; x < LEN_B; x++) begin
            enc_mem[x] = 8'h00;
            dec_mem[x] = 8'h00;
        end
        for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);

        // ---- reset, with start held high (must be ignored) ----
        resetm = 1'b0;
        start  = 1'b1;
        repeat (3) @(negedge clok);
        check("reset outputs", {m_new_char, m_done, m_s_wren, m_dec_wren, m_char_count,
                                m_s_addr, m_char_out, m_enc_addr, m_dec_addr}, 0);
        start  = 1'b0;
        resetm = 1'b1;
        repeat (3) @(negedge clok);
        check("start ignored during reset", {m_new_char, m_s_addr}, 0);

        // ---- table: first byte for several S patterns ----
        for (int v = 0; v < 6; v++) begin
            abort();
            for (int x = 0; x < 256; x++) ref_s[x] = (x + vecs[v].rot) % 256;
            load_s();
            enc_mem[0] = vecs[v].enc;
            pulse_start();
            wait_nc(cyc, ok);
            if (!ok) begin
                fail_timeout($sformatf("vec%0d", v));
            end else begin
                check($sformatf("vec%0d latency", v), cyc + 1, 10);
                check($sformatf("vec%0d char_out", v), m_char_out, vecs[v].exp_char);
                check($sformatf("vec%0d dec[0]", v), dec_mem[0], vecs[v].exp_char);
            end
        end

        // ---- identity, i==j swap, hold in PRESENT, then ack ----
        abort();
        for (int x = 0; x < 256; x++) ref_s[x] = x;
        load_s();
        enc_mem[0] = 8'h00;
        enc_mem[1] = 8'h00;
        pulse_start();
        wait_nc(cyc, ok);
        if (!ok) fail_timeout("hold byte0");
        check("identity S[1] unchanged", s_mem[1], 8'h01);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clok);
            if (m_new_char && m_char_out == 8'h02 && m_char_count == 0) n++;
        end
        check("stable cycles in PRESENT", n, 20);
        compared_char = 1'b1;
        @(negedge clok);
        compared_char = 1'b0;
        check("new_char low after ack", m_new_char, 0);
        @(negedge clok);
        check("char_count after ack", m_char_count, 1);
        cyc = 2;
        while (!m_new_char && cyc < 40) begin
            @(negedge clok);
            cyc++;
        end
        check("ack to next new_char", cyc, 11);
        check("identity byte1", m_char_out, 8'h05);

        // ---- abort in PRESENT ----
        abort();
        check("abort PRESENT outputs", {m_new_char, m_done, m_s_wren, m_dec_wren, m_char_count}, 0);

        // ---- abort in WR_SI (first S write) ----
        load_s();
        pulse_start();
        n = 0;
        while (!m_s_wren && n < 20) begin
            @(negedge clok);
            n++;
        end
        if (!m_s_wren) fail_timeout("reach WR_SI");
        abort();
        check("abort WR_SI outputs", {m_new_char, m_done, m_s_wren, m_dec_wren, m_char_count}, 0);
        wr_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clok);
            if (m_s_wren || m_dec_wren || m_new_char) wr_seen++;
        end
        check("idle after WR_SI abort", wr_seen, 0);
        load_s();
        pulse_start();
        wait_nc(cyc, ok);
        if (!ok) fail_timeout("restart after abort");
        check("restart byte0 (i=j=0)", m_char_out, 8'h02);

        // ---- full run, key 0x000249, known plaintext ----
        abort();
        pt = "the quick brown fox jumps over t";
        model_ksa(8'h00, 8'h02, 8'h49);
        load_s();
        model_keystream(LEN_A);
        for (int k = 0; k < LEN_A; k++) begin
            exp_pt[k]  = pt[k];
            enc_mem[k] = pt[k] ^ 8'(ks[k]);
        end
        pulse_start();
        run_message(LEN_A, "key000249");

        // ---- abort in DONE ----
        abort();
        check("abort DONE outputs", {m_done, m_char_count, m_new_char}, 0);

        // ---- random S and ciphertext on the 32-byte build ----
        for (int r = 0; r < 2; r++) begin
            abort();
            random_perm();
            load_s();
            model_keystream(LEN_A);
            for (int k = 0; k < LEN_A; k++) begin
                enc_mem[k] = 8'($urandom);
                exp_pt[k]  = enc_mem[k] ^ 8'(ks[k]);
            end
            pulse_start();
            run_message(LEN_A, $sformatf("rand%0d", r));
        end

        // ---- reset mid-run while a byte is presented ----
        abort();
        for (int x = 0; x < 256; x++) ref_s[x] = x;
        load_s();
        pulse_start();
        wait_nc(cyc, ok);
        if (!ok) fail_timeout("before mid-run reset");
        resetm = 1'b0;
        start  = 1'b1;
        @(negedge clok);
        check("mid-run reset outputs", {m_new_char, m_done, m_s_wren, m_dec_wren, m_char_count,
                                        m_s_addr, m_char_out}, 0);
        repeat (2) @(negedge clok);
        start  = 1'b0;
        resetm = 1'b1;
        wr_seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clok);
            if (m_new_char || m_s_wren || m_s_addr != 8'h00) wr_seen++;
        end
        check("no activity after reset with start held", wr_seen, 0);

        // ---- 300-byte build: i wraps 255 -> 0 ----
        sel = 1'b1;
        abort();
        random_perm();
        load_s();
        model_keystream(LEN_B);
        for (int k = 0; k < LEN_B; k++) begin
            enc_mem[k] = 8'($urandom);
            exp_pt[k]  = enc_mem[k] ^ 8'(ks[k]);
        end
        pulse_start();
        run_message(LEN_B, "len300");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
